// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch control path.
package stopwatch_pkg;

    localparam int unsigned SCAN_W  = 2;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned PRESC_W = 7;

    // Highest legal value of a units digit and of a tens digit
    localparam logic [DIGIT_W-1:0] BCD_UNITS_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_TENS_MAX  = 4'd5;

    // Digit index driven on scan_sel
    localparam logic [SCAN_W-1:0] DIG_SEC0 = 2'd0;
    localparam logic [SCAN_W-1:0] DIG_SEC1 = 2'd1;
    localparam logic [SCAN_W-1:0] DIG_MIN0 = 2'd2;
    localparam logic [SCAN_W-1:0] DIG_MIN1 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] min1;
        logic [DIGIT_W-1:0] min0;
        logic [DIGIT_W-1:0] sec1;
        logic [DIGIT_W-1:0] sec0;
    } bcd_time_t;

    typedef struct packed {
        logic               carry;
        logic [DIGIT_W-1:0] digit;
    } bcd_step_t;

    // One BCD digit stage: wraps to 0 and carries at (or beyond) its limit
    function automatic bcd_step_t bcd_step(input logic [DIGIT_W-1:0] d,
                                           input logic [DIGIT_W-1:0] lim,
                                           input logic               inc);
        bcd_step_t r;
        r.carry = 1'b0;
        r.digit = d;
        if (inc) begin
            if (d >= lim) begin
                r.carry = 1'b1;
                r.digit = '0;
            end else begin
                r.digit = d + DIGIT_W'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/tick inputs and display-side outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic               tick_100hz;
    logic               scan_tick;
    logic               start_stop;
    logic               lap;
    logic               clear;
    logic [DIGIT_W-1:0] sec0;
    logic [DIGIT_W-1:0] sec1;
    logic [DIGIT_W-1:0] min0;
    logic [DIGIT_W-1:0] min1;
    logic               lap_or_not;
    logic               count_en;
    logic [SCAN_W-1:0]  scan_sel;
    logic               rollover;

    // Button/time-base side
    modport master (
        output tick_100hz, scan_tick, start_stop, lap, clear,
        input  sec0, sec1, min0, min1, lap_or_not, count_en, scan_sel, rollover
    );

    // Stopwatch controller side
    modport slave (
        input  tick_100hz, scan_tick, start_stop, lap, clear,
        output sec0, sec1, min0, min1, lap_or_not, count_en, scan_sel, rollover
    );

endinterface

// File: rtl/bcd_time_counter.sv
// Prescaler plus mm:ss BCD cascade; clear zeroes both, rollover flags 59:59 -> 00:00.
module bcd_time_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned PRESCALE = 100
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      clr,
    input  logic      tick,
    output bcd_time_t count,
    output logic      rollover
);

    logic [PRESC_W-1:0] presc;
    logic               sec_inc_c;
    bcd_step_t          s0_c;
    bcd_step_t          s1_c;
    bcd_step_t          m0_c;
    bcd_step_t          m1_c;

    assign sec_inc_c = en && tick && (presc == PRESC_W'(PRESCALE - 1));

    // Next digit values; each stage increments only on the carry of the one below
    always_comb begin
        s0_c = bcd_step(count.sec0, BCD_UNITS_MAX, sec_inc_c);
        s1_c = bcd_step(count.sec1, BCD_TENS_MAX,  s0_c.carry);
        m0_c = bcd_step(count.min0, BCD_UNITS_MAX, s1_c.carry);
        m1_c = bcd_step(count.min1, BCD_TENS_MAX,  m0_c.carry);
    end

    // Prescaler, digit and rollover registers
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            presc    <= '0;
            count    <= '0;
            rollover <= 1'b0;
        end else begin
            rollover <= m1_c.carry;
            if (en && tick) begin
                if (sec_inc_c) begin
                    presc <= '0;
                end else begin
                    presc <= presc + PRESC_W'(1);
                end
            end
            count.sec0 <= s0_c.digit;
            count.sec1 <= s1_c.digit;
            count.min0 <= m0_c.digit;
            count.min1 <= m1_c.digit;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM, digit-scan counter and time base instance.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned PRESCALE = 100
) (
    input  logic           clk,
    input  logic           rst,
    stopwatch_ctrl_if.slave bus
);

    sw_state_t         state;
    logic              count_en;
    logic              lap_or_not;
    logic [SCAN_W-1:0] scan_sel;
    logic              zero_c;
    bcd_time_t         count;
    logic              rollover;

    // Clear only acts from PAUSE, and it zeroes the time base on the same edge
    assign zero_c = (state == PAUSE) && bus.clear;

    // FSM; count_en/lap_or_not are registered together with the state they decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count_en   <= 1'b0;
            lap_or_not <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start_stop) begin
                        state    <= RUN;
                        count_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.start_stop) begin
                        state    <= PAUSE;
                        count_en <= 1'b0;
                    end else if (bus.lap) begin
                        state      <= LAP;
                        lap_or_not <= 1'b0;
                    end
                end
                LAP: begin
                    if (bus.start_stop) begin
                        state      <= PAUSE;
                        count_en   <= 1'b0;
                        lap_or_not <= 1'b1;
                    end else if (bus.lap) begin
                        state      <= RUN;
                        lap_or_not <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (bus.clear) begin
                        state <= IDLE;
                    end else if (bus.start_stop) begin
                        state    <= RUN;
                        count_en <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    count_en   <= 1'b0;
                    lap_or_not <= 1'b1;
                end
            endcase
        end
    end

    // Free-running digit scan, modulo 4, independent of the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_sel <= DIG_SEC0;
        end else if (bus.scan_tick) begin
            scan_sel <= (scan_sel == DIG_MIN1) ? DIG_SEC0 : scan_sel + SCAN_W'(1);
        end
    end

    bcd_time_counter #(
        .PRESCALE (PRESCALE)
    ) u_time (
        .clk      (clk),
        .rst      (rst),
        .en       (count_en),
        .clr      (zero_c),
        .tick     (bus.tick_100hz),
        .count    (count),
        .rollover (rollover)
    );

    assign bus.sec0       = count.sec0;
    assign bus.sec1       = count.sec1;
    assign bus.min0       = count.min0;
    assign bus.min1       = count.min1;
    assign bus.count_en   = count_en;
    assign bus.lap_or_not = lap_or_not;
    assign bus.scan_sel   = scan_sel;
    assign bus.rollover   = rollover;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench: dut_a uses the real 100-tick prescaler, dut_b a 2-tick
// prescaler so a full hour of counting fits in a short run.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb[$];

    typedef struct {
        string       tag;
        bit          rs, ss, lp, cl, tk, sc;
        int          reps;
        logic [15:0] dig;
        bit          cen, lon;
        logic [1:0]  scan;
        bit          rov;
    } step_t;

    stopwatch_ctrl_if ifa ();
    stopwatch_ctrl_if ifb ();

    stopwatch_ctrl #(.PRESCALE(100)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
    stopwatch_ctrl #(.PRESCALE(2))   dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

    always #5 clk = ~clk;

    function automatic step_t mk(string tag, bit rs, bit ss, bit lp, bit cl, bit tk, bit sc,
                                 int reps, logic [15:0] dig, bit cen, bit lon,
                                 logic [1:0] scan, bit rov);
        step_t s;
        s.tag = tag; s.rs = rs; s.ss = ss; s.lp = lp; s.cl = cl; s.tk = tk; s.sc = sc;
        s.reps = reps; s.dig = dig; s.cen = cen; s.lon = lon; s.scan = scan; s.rov = rov;
        return s;
    endfunction

    function automatic logic [31:0] exp_of(step_t s);
        return {s.dig, 3'b0, s.cen, 3'b0, s.lon, 2'b0, s.scan, 3'b0, s.rov};
    endfunction

    function automatic logic [31:0] snap(bit sel);
        if (sel)
            return {ifb.min1, ifb.min0, ifb.sec1, ifb.sec0, 3'b0, ifb.count_en,
                    3'b0, ifb.lap_or_not, 2'b0, ifb.scan_sel, 3'b0, ifb.rollover};
        return {ifa.min1, ifa.min0, ifa.sec1, ifa.sec0, 3'b0, ifa.count_en,
                3'b0, ifa.lap_or_not, 2'b0, ifa.scan_sel, 3'b0, ifa.rollover};
    endfunction

    task automatic drive(bit sel, bit rs, bit ss, bit lp, bit cl, bit tk, bit sc);
        if (sel) begin
            rst_b = rs; ifb.start_stop = ss; ifb.lap = lp; ifb.clear = cl;
            ifb.tick_100hz = tk; ifb.scan_tick = sc;
        end else begin
            rst_a = rs; ifa.start_stop = ss; ifa.lap = lp; ifa.clear = cl;
            ifa.tick_100hz = tk; ifa.scan_tick = sc;
        end
    endtask

    // Hold the step's inputs for reps clocks, then sample 1 time unit after the edge
    task automatic exec(bit sel, step_t s, output logic [31:0] obs);
        repeat (s.reps) begin
            drive(sel, s.rs, s.ss, s.lp, s.cl, s.tk, s.sc);
            @(posedge clk);
            #1;
            drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        obs = snap(sel);
    endtask

    task automatic test_reset();
        step_t st[$];
        logic [31:0] obs, e;
        st.push_back(mk("rst_hold",   1,0,0,0,0,0,   2, 16'h0000, 0,1, 2'd0, 0));
        st.push_back(mk("scan1",      0,0,0,0,0,1,   1, 16'h0000, 0,1, 2'd1, 0));
        st.push_back(mk("scan2",      0,0,0,0,0,1,   1, 16'h0000, 0,1, 2'd2, 0));
        st.push_back(mk("scan3",      0,0,0,0,0,1,   1, 16'h0000, 0,1, 2'd3, 0));
        st.push_back(mk("scan_wrap",  0,0,0,0,0,1,   1, 16'h0000, 0,1, 2'd0, 0));
        st.push_back(mk("idle_ticks", 0,0,0,0,1,0, 300, 16'h0000, 0,1, 2'd0, 0));
        foreach (st[i]) begin
            sb.push_back(exp_of(st[i]));
            exec(1'b0, st[i], obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset/%s: got %h expected %h", st[i].tag, obs, e);
            end
        end
    endtask

    task automatic test_run_pause();
        step_t st[$];
        logic [31:0] obs, e;
        st.push_back(mk("start",      0,1,0,0,0,0,   1, 16'h0000, 1,1, 2'd0, 0));
        st.push_back(mk("run250",     0,0,0,0,1,0, 250, 16'h0002, 1,1, 2'd0, 0));
        st.push_back(mk("pause",      0,1,0,0,0,0,   1, 16'h0002, 0,1, 2'd0, 0));
        st.push_back(mk("paused100",  0,0,0,0,1,0, 100, 16'h0002, 0,1, 2'd0, 0));
        st.push_back(mk("resume",     0,1,0,0,0,0,   1, 16'h0002, 1,1, 2'd0, 0));
        st.push_back(mk("run49",      0,0,0,0,1,0,  49, 16'h0002, 1,1, 2'd0, 0));
        st.push_back(mk("run50th",    0,0,0,0,1,0,   1, 16'h0003, 1,1, 2'd0, 0));
        foreach (st[i]) begin
            sb.push_back(exp_of(st[i]));
            exec(1'b0, st[i], obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL run_pause/%s: got %h expected %h", st[i].tag, obs, e);
            end
        end
    endtask

    task automatic test_lap();
        step_t st[$];
        logic [31:0] obs, e;
        st.push_back(mk("clear_in_run", 0,0,0,1,0,0,   1, 16'h0003, 1,1, 2'd0, 0));
        st.push_back(mk("lap_enter",    0,0,1,0,0,0,   1, 16'h0003, 1,0, 2'd0, 0));
        st.push_back(mk("lap_advance",  0,0,0,0,1,0, 100, 16'h0004, 1,0, 2'd0, 0));
        st.push_back(mk("clear_in_lap", 0,0,0,1,0,0,   1, 16'h0004, 1,0, 2'd0, 0));
        st.push_back(mk("lap_release",  0,0,1,0,0,0,   1, 16'h0004, 1,1, 2'd0, 0));
        st.push_back(mk("run30",        0,0,0,0,1,0,  30, 16'h0004, 1,1, 2'd0, 0));
        st.push_back(mk("lap_again",    0,0,1,0,0,0,   1, 16'h0004, 1,0, 2'd0, 0));
        st.push_back(mk("ss_from_lap",  0,1,0,0,0,0,   1, 16'h0004, 0,1, 2'd0, 0));
        foreach (st[i]) begin
            sb.push_back(exp_of(st[i]));
            exec(1'b0, st[i], obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL lap/%s: got %h expected %h", st[i].tag, obs, e);
            end
        end
    endtask

    task automatic test_priority();
        step_t st[$];
        logic [31:0] obs, e;
        st.push_back(mk("lap_in_pause",   0,0,1,0,0,0,   1, 16'h0004, 0,1, 2'd0, 0));
        st.push_back(mk("tick_in_pause",  0,0,0,0,1,0,  10, 16'h0004, 0,1, 2'd0, 0));
        st.push_back(mk("clear_ss_pause", 0,1,0,1,0,0,   1, 16'h0000, 0,1, 2'd0, 0));
        st.push_back(mk("lap_in_idle",    0,0,1,0,0,0,   1, 16'h0000, 0,1, 2'd0, 0));
        st.push_back(mk("clear_in_idle",  0,0,0,1,0,0,   1, 16'h0000, 0,1, 2'd0, 0));
        st.push_back(mk("tick_in_idle",   0,0,0,0,1,0, 150, 16'h0000, 0,1, 2'd0, 0));
        st.push_back(mk("start",          0,1,0,0,0,0,   1, 16'h0000, 1,1, 2'd0, 0));
        st.push_back(mk("run99",          0,0,0,0,1,0,  99, 16'h0000, 1,1, 2'd0, 0));
        st.push_back(mk("run100th",       0,0,0,0,1,0,   1, 16'h0001, 1,1, 2'd0, 0));
        st.push_back(mk("ss_lap_tick",    0,1,1,0,1,0,   1, 16'h0001, 0,1, 2'd0, 0));
        st.push_back(mk("ss_tick_pause",  0,1,0,0,1,0,   1, 16'h0001, 1,1, 2'd0, 0));
        st.push_back(mk("run98",          0,0,0,0,1,0,  98, 16'h0001, 1,1, 2'd0, 0));
        st.push_back(mk("run_last",       0,0,0,0,1,0,   1, 16'h0002, 1,1, 2'd0, 0));
        foreach (st[i]) begin
            sb.push_back(exp_of(st[i]));
            exec(1'b0, st[i], obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL priority/%s: got %h expected %h", st[i].tag, obs, e);
            end
        end
    endtask

    task automatic test_rollover();
        step_t st[$];
        logic [31:0] obs, e;
        st.push_back(mk("rst",        1,0,0,0,0,0,    2, 16'h0000, 0,1, 2'd0, 0));
        st.push_back(mk("start",      0,1,0,0,0,0,    1, 16'h0000, 1,1, 2'd0, 0));
        st.push_back(mk("to_59_59",   0,0,0,0,1,0, 7199, 16'h5959, 1,1, 2'd0, 0));
        st.push_back(mk("wrap",       0,0,0,0,1,0,    1, 16'h0000, 1,1, 2'd0, 1));
        st.push_back(mk("wrap_after", 0,0,0,0,0,0,    1, 16'h0000, 1,1, 2'd0, 0));
        st.push_back(mk("keep_going", 0,0,0,0,1,0,    2, 16'h0001, 1,1, 2'd0, 0));
        foreach (st[i]) begin
            sb.push_back(exp_of(st[i]));
            exec(1'b1, st[i], obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL rollover/%s: got %h expected %h", st[i].tag, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_lap();
        step_t st[$];
        logic [31:0] obs, e;
        st.push_back(mk("rst",         1,0,0,0,0,0,    1, 16'h0000, 0,1, 2'd0, 0));
        st.push_back(mk("start",       0,1,0,0,0,0,    1, 16'h0000, 1,1, 2'd0, 0));
        st.push_back(mk("to_12_34",    0,0,0,0,1,0, 1508, 16'h1234, 1,1, 2'd0, 0));
        st.push_back(mk("lap",         0,0,1,0,0,0,    1, 16'h1234, 1,0, 2'd0, 0));
        st.push_back(mk("scan3",       0,0,0,0,0,1,    3, 16'h1234, 1,0, 2'd3, 0));
        st.push_back(mk("rst_mid_lap", 1,0,0,0,1,0,    1, 16'h0000, 0,1, 2'd0, 0));
        st.push_back(mk("idle_after",  0,0,0,0,1,0,    5, 16'h0000, 0,1, 2'd0, 0));
        foreach (st[i]) begin
            sb.push_back(exp_of(st[i]));
            exec(1'b1, st[i], obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid_lap/%s: got %h expected %h", st[i].tag, obs, e);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_run_pause();
        test_lap();
        test_priority();
        test_rollover();
        test_reset_mid_lap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
